// File: rtl/noc_pkg.sv
// Shared NoC types: flit types, output ports, input-port FSM states and the XY routing function.
package noc_pkg;

  typedef enum logic [1:0] {
    FlitHead     = 2'b00,
    FlitBody     = 2'b01,
    FlitTail     = 2'b10,
    FlitHeadTail = 2'b11
  } flit_type_t;

  typedef enum logic [2:0] {
    PortLocal = 3'd0,
    PortNorth = 3'd1,
    PortSouth = 3'd2,
    PortWest  = 3'd3,
    PortEast  = 3'd4
  } port_t;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StActive = 1'b1
  } state_t;

  // Callers zero-extend their coordinates to this width, so comparisons stay unsigned.
  localparam int unsigned MaxCoordW = 16;

  function automatic port_t route_xy(input logic [MaxCoordW-1:0] dest_x,
                                     input logic [MaxCoordW-1:0] dest_y,
                                     input logic [MaxCoordW-1:0] cur_x,
                                     input logic [MaxCoordW-1:0] cur_y);
    port_t port;
    if (dest_x > cur_x) begin
      port = PortEast;
    end else if (dest_x < cur_x) begin
      port = PortWest;
    end else if (dest_y > cur_y) begin
      port = PortNorth;
    end else if (dest_y < cur_y) begin
      port = PortSouth;
    end else begin
      port = PortLocal;
    end
    return port;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with full/empty/count, no bypass. A write into a full FIFO is
// accepted only when a read happens in the same cycle.
module noc_fifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW  = $clog2(Depth),
  localparam int unsigned CountW = AddrW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [Width-1:0]  wr_data,
  input  logic              rd_en,
  output logic [Width-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [CountW-1:0] count
);

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              do_wr, do_rd;

  assign full  = (count_q == CountW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q <= count_q + CountW'(do_wr) - CountW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/router_input_port.sv
// NoC router input unit: flit buffer, XY route lock per packet, valid/ready to the switch,
// one credit per flit leaving the buffer. Define ROUTER_PORT_STATS_EN for flit/packet counters.
module router_input_port
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH  = 32,
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned COORD_W     = 4,
  parameter int unsigned X_CURRENT   = 0,
  parameter int unsigned Y_CURRENT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [FLIT_WIDTH+1:0] in_flit,
  output logic                  credit_out,
  output logic                  out_valid,
  output logic [FLIT_WIDTH+1:0] out_flit,
  output logic [2:0]            out_port,
  input  logic                  out_ready,
  output logic                  overflow_err,
  output logic                  proto_err
`ifdef ROUTER_PORT_STATS_EN
  ,
  output logic [15:0]           flit_count,
  output logic [15:0]           pkt_count
`endif
);

  localparam int unsigned CountW = $clog2(BUFFER_SIZE) + 1;
  localparam logic [COORD_W-1:0] XCur = COORD_W'(X_CURRENT);
  localparam logic [COORD_W-1:0] YCur = COORD_W'(Y_CURRENT);

  state_t               state_q, state_d;
  port_t                out_port_q;
  logic                 credit_q, overflow_q, proto_q;
  logic                 fifo_full, fifo_empty;
  logic [CountW-1:0]    fifo_count;
  logic [FLIT_WIDTH+1:0] front;
  flit_type_t           front_type;
  logic                 front_is_head, front_is_tail;
  logic [MaxCoordW-1:0] dest_x, dest_y;
  logic                 deq, route_en, orphan, fwd, mid_head;

  noc_fifo #(
    .Width(FLIT_WIDTH + 2),
    .Depth(BUFFER_SIZE)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (in_valid),
    .wr_data(in_flit),
    .rd_en  (deq),
    .rd_data(front),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign front_type    = flit_type_t'(front[FLIT_WIDTH+1:FLIT_WIDTH]);
  assign front_is_head = (front_type == FlitHead) || (front_type == FlitHeadTail);
  assign front_is_tail = (front_type == FlitTail) || (front_type == FlitHeadTail);
  assign dest_x        = MaxCoordW'(front[COORD_W-1:0]);
  assign dest_y        = MaxCoordW'(front[2*COORD_W-1:COORD_W]);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!fifo_empty && front_is_head) state_d = StActive;
      StActive: if (deq && front_is_tail) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Routing the head costs one cycle with no dequeue; stray body/tail flits are dropped in idle.
  always_comb begin
    out_valid = 1'b0;
    deq       = 1'b0;
    route_en  = 1'b0;
    orphan    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          if (front_is_head) begin
            route_en = 1'b1;
          end else begin
            deq    = 1'b1;
            orphan = 1'b1;
          end
        end
      end
      StActive: begin
        out_valid = !fifo_empty;
        deq       = !fifo_empty && out_ready;
      end
      default: ;
    endcase
  end

  assign fwd      = (state_q == StActive) && deq;
  assign mid_head = fwd && (front_type == FlitHead);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_port_q <= PortLocal;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      if (route_en) begin
        out_port_q <= route_xy(dest_x, dest_y, MaxCoordW'(XCur), MaxCoordW'(YCur));
      end
      credit_q <= deq;
      if (in_valid && fifo_full && !deq) overflow_q <= 1'b1;
      if (orphan || mid_head) proto_q <= 1'b1;
    end
  end

  assign out_flit     = front;
  assign out_port     = out_port_q;
  assign credit_out   = credit_q;
  assign overflow_err = overflow_q;
  assign proto_err    = proto_q;

  // Occupancy can never exceed the buffer depth.
  assert property (@(posedge clk) disable iff (!rst) fifo_count <= CountW'(BUFFER_SIZE));

`ifdef ROUTER_PORT_STATS_EN
  logic [15:0] flit_cnt_q, pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (fwd) begin
      if (flit_cnt_q != 16'hFFFF) flit_cnt_q <= flit_cnt_q + 16'd1;
      if (front_is_tail && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign flit_count = flit_cnt_q;
  assign pkt_count  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_router_input_port.sv
// Scoreboard bench for router_input_port at router (1,1): directed scenarios, then random
// credit-respecting packet traffic checked against a packet-level reference model.
module tb_router_input_port;

  localparam int FW = 32;
  localparam int BS = 8;
  localparam int CW = 4;
  localparam int XC = 1;
  localparam int YC = 1;
  localparam int TW = FW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [TW-1:0] in_flit = '0;
  logic [TW-1:0] out_flit;
  logic          credit_out, out_valid, overflow_err, proto_err;
  logic [2:0]    out_port;
`ifdef ROUTER_PORT_STATS_EN
  logic [15:0]   flit_count, pkt_count;
`endif

  router_input_port #(
    .FLIT_WIDTH (FW),
    .BUFFER_SIZE(BS),
    .COORD_W    (CW),
    .X_CURRENT  (XC),
    .Y_CURRENT  (YC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_flit     (in_flit),
    .credit_out  (credit_out),
    .out_valid   (out_valid),
    .out_flit    (out_flit),
    .out_port    (out_port),
    .out_ready   (out_ready),
    .overflow_err(overflow_err),
    .proto_err   (proto_err)
`ifdef ROUTER_PORT_STATS_EN
    ,
    .flit_count  (flit_count),
    .pkt_count   (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model state: sender-side packet view plus expected {port, flit} stream.
  logic [TW+2:0] exp_q[$];
  logic [TW+2:0] mon_e;
  bit            in_pkt = 0;
  logic [2:0]    cur_port = 3'd0;
  bit            exp_proto = 0;
  int            sent = 0;
  int            credits_seen = 0;
  int            hs_total = 0;
  int            cyc = 0;
  int            hs_cyc_q[$];
  bit            done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_route(input int dx, input int dy);
    if (dx > XC) return 3'd4;
    if (dx < XC) return 3'd3;
    if (dy > YC) return 3'd1;
    if (dy < YC) return 3'd2;
    return 3'd0;
  endfunction

  function automatic logic [TW-1:0] mkf(input int t, input int x, input int y, input int tag);
    logic [TW-1:0] f;
    f = '0;
    f[TW-1:FW]    = t[1:0];
    f[CW-1:0]     = x[CW-1:0];
    f[2*CW-1:CW]  = y[CW-1:0];
    f[FW-1:2*CW]  = tag[FW-2*CW-1:0];
    return f;
  endfunction

  task automatic model_send(input logic [TW-1:0] f);
    int t  = int'(f[TW-1:FW]);
    int dx = int'(f[CW-1:0]);
    int dy = int'(f[2*CW-1:CW]);
    sent++;
    if (!in_pkt) begin
      if (t == 0 || t == 3) begin
        cur_port = ref_route(dx, dy);
        exp_q.push_back({cur_port, f});
        in_pkt = (t == 0);
      end else begin
        exp_proto = 1;
      end
    end else begin
      exp_q.push_back({cur_port, f});
      if (t == 0) exp_proto = 1;
      if (t == 2 || t == 3) in_pkt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; the flit is written at the following edge.
  task automatic send(input logic [TW-1:0] f, input bit accept);
    in_valid = 1'b1;
    in_flit  = f;
    if (accept) model_send(f);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_credit(input logic [TW-1:0] f);
    int w = 0;
    while ((BS - sent + credits_seen) <= 0 && w < 200) begin
      step();
      w++;
    end
    checks++;
    if (w >= 200) begin
      fails++;
      $display("FAIL credit_wait: waited %0d cycles, expected a returned credit", w);
    end
    send(f, 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (n) step();
    rst = 1'b1;
    in_pkt = 0;
    exp_proto = 0;
    sent = 0;
    credits_seen = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (credit_out) credits_seen++;
      if (out_valid && out_ready) begin
        hs_total++;
        hs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_flit: got port %0d flit %0h, expected none", out_port, out_flit);
        end else begin
          mon_e = exp_q.pop_front();
          check("flit_port", 64'({out_port, out_flit}), 64'(mon_e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c0, h0, w;
    bit ov_seen;

    // Reset values
    do_reset(2);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_credit", 64'(credit_out), 64'd0);
    check("rst_overflow", 64'(overflow_err), 64'd0);
    check("rst_proto", 64'(proto_err), 64'd0);
    check("rst_out_port", 64'(out_port), 64'd0);
    step();

    // HEADTAIL to (3,1): east, valid two cycles after the write, one credit
    out_ready = 1'b1;
    c0 = credits_seen;
    send(mkf(3, 3, 1, 11), 1);
    @(negedge clk);
    check("ht_valid_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("ht_valid", 64'(out_valid), 64'd1);
    check("ht_port", 64'(out_port), 64'd4);
    @(negedge clk);
    check("ht_credit_pulse", 64'(credit_out), 64'd1);
    check("ht_back_idle", 64'(out_valid), 64'd0);
    step();
    repeat (2) step();
    check("ht_credits", 64'(credits_seen - c0), 64'd1);

    // HEAD (1,0), 3 BODY, TAIL streamed back to back
    hs_cyc_q.delete();
    c0 = credits_seen;
    send(mkf(0, 1, 0, 20), 1);
    for (int i = 0; i < 3; i++) send(mkf(1, 0, 0, 21 + i), 1);
    send(mkf(2, 0, 0, 24), 1);
    repeat (8) step();
    check("pkt_handshakes", 64'(hs_cyc_q.size()), 64'd5);
    if (hs_cyc_q.size() == 5) check("pkt_consecutive", 64'(hs_cyc_q[4] - hs_cyc_q[0]), 64'd4);
    check("pkt_credits", 64'(credits_seen - c0), 64'd5);
    check("pkt_port", 64'(out_port), 64'd2);

    // Overflow: 9 writes with the switch stalled, then a write alongside a dequeue
    out_ready = 1'b0;
    h0 = hs_total;
    send(mkf(0, 0, 1, 30), 1);
    for (int i = 1; i < 8; i++) send(mkf(1, 0, 0, 30 + i), 1);
    @(negedge clk);
    check("ovf_before", 64'(overflow_err), 64'd0);
    step();
    send(mkf(1, 0, 0, 99), 0);
    @(negedge clk);
    check("ovf_set", 64'(overflow_err), 64'd1);
    check("ovf_valid_held", 64'(out_valid), 64'd1);
    step();
    out_ready = 1'b1;
    send(mkf(1, 0, 0, 40), 1);
    send(mkf(2, 0, 0, 41), 1);
    repeat (14) step();
    check("ovf_drain", 64'(hs_total - h0), 64'd10);
    check("ovf_sticky", 64'(overflow_err), 64'd1);
    do_reset(2);
    @(negedge clk);
    check("ovf_cleared", 64'(overflow_err), 64'd0);
    step();

    // Orphan BODY: discarded with a credit and a protocol error
    c0 = credits_seen;
    h0 = hs_total;
    ov_seen = 0;
    send(mkf(1, 2, 2, 50), 1);
    repeat (4) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1;
      step();
    end
    check("orphan_no_valid", 64'(ov_seen), 64'd0);
    check("orphan_proto", 64'(proto_err), 64'd1);
    check("orphan_credit", 64'(credits_seen - c0), 64'd1);
    check("orphan_no_fwd", 64'(hs_total - h0), 64'd0);

    // Reset with three flits queued mid-packet
    do_reset(2);
    out_ready = 1'b0;
    send(mkf(0, 2, 2, 60), 1);
    send(mkf(1, 0, 0, 61), 1);
    send(mkf(1, 0, 0, 62), 1);
    @(negedge clk);
    check("mid_port_locked", 64'(out_port), 64'd4);
    step();
    do_reset(1);
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_port", 64'(out_port), 64'd0);
    check("mid_rst_proto", 64'(proto_err), 64'd0);
    step();
    out_ready = 1'b1;
    h0 = hs_total;
    repeat (4) step();
    check("mid_rst_no_credit", 64'(credits_seen), 64'd0);
    check("mid_rst_no_fwd", 64'(hs_total - h0), 64'd0);

    // New HEAD (1,1) after reset routes local
    h0 = hs_total;
    send(mkf(0, 1, 1, 70), 1);
    send(mkf(2, 0, 0, 71), 1);
    @(negedge clk);
    check("local_port", 64'(out_port), 64'd0);
    step();
    repeat (4) step();
    check("local_fwd", 64'(hs_total - h0), 64'd2);

    // Random credit-respecting traffic
    do_reset(2);
    done = 0;
    fork
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
      begin
        for (int p = 0; p < 40; p++) begin
          int nb;
          nb = $urandom_range(0, 4);
          if ($urandom_range(0, 9) == 0) send_credit(mkf($urandom_range(1, 2), 0, 0, $urandom));
          if (nb == 0) begin
            send_credit(mkf(3, $urandom_range(0, 3), $urandom_range(0, 3), $urandom));
          end else begin
            send_credit(mkf(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom));
            for (int b = 0; b < nb; b++) begin
              if ($urandom_range(0, 9) == 0)
                send_credit(mkf(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom));
              else
                send_credit(mkf(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom));
            end
            send_credit(mkf(2, $urandom_range(0, 15), $urandom_range(0, 15), $urandom));
          end
          repeat ($urandom_range(0, 2)) step();
        end
        done = 1;
      end
    join
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      step();
      w++;
    end
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    repeat (4) step();
    check("rand_credits", 64'(credits_seen), 64'(sent));
    check("rand_proto", 64'(proto_err), 64'(exp_proto));
    check("rand_overflow", 64'(overflow_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
